// File: rtl/step_motion_pkg.sv
// Shared types and default timing for the step motion sequencer.
package step_motion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    HOLD,
    RELEASE
  } state_t;

  localparam int unsigned DEF_PERIOD_W     = 16;
  localparam int unsigned DEF_STEPS_W      = 16;
  localparam int unsigned DEF_START_PERIOD = 100;
  localparam int unsigned DEF_MIN_PERIOD   = 20;
  localparam int unsigned DEF_ACCEL_DEC    = 20;
  localparam int unsigned DEF_PULSE_W      = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 1000;

  localparam logic DIR_CW     = 1'b1;
  localparam logic DIR_CCW    = 1'b0;
  localparam logic STEP_FULL  = 1'b1;
  localparam logic STEP_HALF  = 1'b0;

endpackage

// File: rtl/step_pulse_timer.sv
// One-shot step pulse generator: on load, raises step_pulse for 'width'
// cycles and strobes gap_elapsed exactly 'gap' cycles after the rising edge.
module step_pulse_timer #(
  parameter int unsigned PERIOD_W = step_motion_pkg::DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] gap,
  input  logic [PERIOD_W-1:0] width,
  output logic                step_pulse,
  output logic                gap_elapsed
);

  logic [PERIOD_W-1:0] gap_cnt;
  logic [PERIOD_W-1:0] width_cnt;
  logic                running;

  // Strobe is valid in the cycle before the edge that ends the gap, so a
  // reload on that edge places the next rising edge exactly 'gap' apart.
  assign gap_elapsed = running && (gap_cnt == '0);

  // Pulse high-time and gap countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_pulse <= 1'b0;
      gap_cnt    <= '0;
      width_cnt  <= '0;
      running    <= 1'b0;
    end else if (load) begin
      step_pulse <= 1'b1;
      width_cnt  <= width - 1'b1;
      gap_cnt    <= gap - 1'b1;
      running    <= 1'b1;
    end else begin
      if (width_cnt != '0) begin
        width_cnt <= width_cnt - 1'b1;
      end else begin
        step_pulse <= 1'b0;
      end
      if (running) begin
        if (gap_cnt == '0) begin
          running <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/step_motion_sequencer.sv
// Trapezoidal step sequencer: turns queued move commands into step_pulse,
// direction, step_size and zero_state for the stepper phase driver.
module step_motion_sequencer
  import step_motion_pkg::*;
#(
  parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
  parameter int unsigned STEPS_W      = DEF_STEPS_W,
  parameter int unsigned START_PERIOD = DEF_START_PERIOD,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned ACCEL_DEC    = DEF_ACCEL_DEC,
  parameter int unsigned PULSE_W      = DEF_PULSE_W,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic               cmd_full,
  input  logic               abort,
  output logic               step_pulse,
  output logic               direction,
  output logic               step_size,
  output logic               zero_state,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] pulses_left
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PERIOD_W-1:0] START_P   = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_P    = PERIOD_W'(ACCEL_DEC);
  localparam logic [PERIOD_W-1:0] PULSE_P   = PERIOD_W'(PULSE_W);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] next_period;
  logic [STEPS_W-1:0]  ramp;
  logic [STEPS_W-1:0]  next_ramp;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                launch;

  logic                accept;
  logic                moving;
  logic                abort_ok;
  logic [STEPS_W:0]    dbl_steps;
  logic [STEPS_W-1:0]  n_total;
  logic [STEPS_W:0]    ramp_p1;
  logic [STEPS_W-1:0]  eff_left;
  logic [STEPS_W-1:0]  rem;
  logic                emit;
  logic                finish;
  logic                rel_fire;
  logic                load;
  logic [PERIOD_W-1:0] load_gap;
  logic                gap_elapsed;
  logic [PERIOD_W:0]   period_up;

  assign cmd_ready = (state == IDLE) || (state == HOLD);
  assign moving    = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign busy      = moving;
  assign accept    = cmd_valid && cmd_ready;

  // Full-step moves need two driver pulses per step; saturate on overflow.
  assign dbl_steps = {cmd_steps, 1'b0};
  assign n_total   = !cmd_full ? cmd_steps
                   : (dbl_steps[STEPS_W] ? '1 : dbl_steps[STEPS_W-1:0]);

  // A stop trims the remaining count to ramp+1 so the next pulse sees
  // rem == ramp and the existing deceleration path unwinds the ramp.
  // Never extends a move that is already closer to its end.
  assign abort_ok = abort && ((state == ACCEL) || (state == CRUISE));
  assign ramp_p1  = {1'b0, ramp} + 1'b1;
  assign eff_left = (abort_ok && ({1'b0, pulses_left} > ramp_p1))
                  ? ramp_p1[STEPS_W-1:0] : pulses_left;

  assign emit     = moving && (launch || gap_elapsed) && (eff_left != '0);
  assign finish   = moving && gap_elapsed && (pulses_left == '0);
  assign rem      = eff_left - 1'b1;
  assign rel_fire = (state == RELEASE) && launch;
  assign load     = emit || rel_fire;
  // The last pulse and the release pulse only need their high time timed.
  assign load_gap = (rel_fire || (rem == '0)) ? PULSE_P : period;

  assign period_up = {1'b0, period} + {1'b0, STEP_P};

  // Profile update for the pulse being emitted, keyed on pulses remaining.
  always_comb begin
    next_state  = state;
    next_period = period;
    next_ramp   = ramp;
    if (rem == '0) begin
      next_state = state;
    end else if (rem <= ramp) begin
      next_state  = DECEL;
      next_period = (period_up >= {1'b0, START_P}) ? START_P : period_up[PERIOD_W-1:0];
      next_ramp   = (ramp == '0) ? ramp : ramp - 1'b1;
    end else if (period > MIN_P) begin
      next_state  = ACCEL;
      next_period = ((period - MIN_P) <= STEP_P) ? MIN_P : period - STEP_P;
      next_ramp   = (ramp == '1) ? ramp : ramp + 1'b1;
    end else begin
      next_state = CRUISE;
    end
  end

  // Sequencer FSM: command accept, per-pulse profile, hold and release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      period      <= START_P;
      ramp        <= '0;
      pulses_left <= '0;
      hold_cnt    <= '0;
      launch      <= 1'b0;
      direction   <= DIR_CCW;
      step_size   <= STEP_HALF;
      zero_state  <= 1'b1;
      done        <= 1'b0;
    end else begin
      done   <= (state == HOLD) && launch;
      launch <= 1'b0;
      if (accept) begin
        direction   <= cmd_dir ? DIR_CW : DIR_CCW;
        step_size   <= cmd_full ? STEP_FULL : STEP_HALF;
        zero_state  <= 1'b0;
        period      <= START_P;
        ramp        <= '0;
        pulses_left <= n_total;
        hold_cnt    <= '0;
        launch      <= 1'b1;
        state       <= (n_total == '0) ? HOLD : ACCEL;
      end else begin
        case (state)
          ACCEL, CRUISE, DECEL: begin
            if (finish) begin
              done     <= 1'b1;
              hold_cnt <= '0;
              state    <= HOLD;
            end else if (emit) begin
              pulses_left <= rem;
              period      <= next_period;
              ramp        <= next_ramp;
              state       <= next_state;
            end else begin
              pulses_left <= eff_left;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              zero_state <= 1'b1;
              launch     <= 1'b1;
              hold_cnt   <= '0;
              state      <= RELEASE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (!launch && gap_elapsed) begin
              state <= IDLE;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  step_pulse_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .gap         (load_gap),
    .width       (PULSE_P),
    .step_pulse  (step_pulse),
    .gap_elapsed (gap_elapsed)
  );

endmodule

// File: tb/tb_step_motion_sequencer.sv
// Directed bench for step_motion_sequencer with default timing parameters.
module tb_step_motion_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        cmd_full = 1'b0;
  logic        abort = 1'b0;
  logic        step_pulse;
  logic        direction;
  logic        step_size;
  logic        zero_state;
  logic        busy;
  logic        done;
  logic [15:0] pulses_left;

  step_motion_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_steps   (cmd_steps),
    .cmd_dir     (cmd_dir),
    .cmd_full    (cmd_full),
    .abort       (abort),
    .step_pulse  (step_pulse),
    .direction   (direction),
    .step_size   (step_size),
    .zero_state  (zero_state),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of rising edges (with the outputs seen at that edge), pulse
  // widths and done strobes.
  int   rise_cyc[$];
  int   rise_dir[$];
  int   rise_size[$];
  int   rise_zero[$];
  int   rise_busy[$];
  int   rise_left[$];
  int   rise_ready[$];
  int   widths[$];
  int   done_cyc[$];
  int   hi = 0;
  logic prev = 1'b0;

  always @(negedge clk) begin
    if (step_pulse && !prev) begin
      rise_cyc.push_back(cyc);
      rise_dir.push_back(int'(direction));
      rise_size.push_back(int'(step_size));
      rise_zero.push_back(int'(zero_state));
      rise_busy.push_back(int'(busy));
      rise_left.push_back(int'(pulses_left));
      rise_ready.push_back(int'(cmd_ready));
    end
    if (step_pulse) begin
      hi <= hi + 1;
    end else if (hi > 0) begin
      widths.push_back(hi);
      hi <= 0;
    end
    if (done) done_cyc.push_back(cyc);
    prev <= step_pulse;
  end

  int checks = 0;
  int errors = 0;
  int acc = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete(); rise_dir.delete(); rise_size.delete();
    rise_zero.delete(); rise_busy.delete(); rise_left.delete();
    rise_ready.delete(); widths.delete(); done_cyc.delete();
  endtask

  task automatic send(input int steps, input logic dir, input logic full);
    int n = 0;
    while (!cmd_ready && n < 3000) begin step(); n++; end
    check("ready_for_cmd", int'(cmd_ready), 1);
    cmd_steps = 16'(steps);
    cmd_dir   = dir;
    cmd_full  = full;
    cmd_valid = 1'b1;
    acc = cyc + 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int limit);
    int k = 0;
    while (rise_cyc.size() < n && k < limit) begin step(); k++; end
    check("rise_wait", int'(rise_cyc.size() >= n), 1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cyc.size() == 0 && k < limit) begin step(); k++; end
    check("done_wait", int'(done_cyc.size() > 0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse"}, int'(step_pulse), 0);
    check({tag, "_zero"},  int'(zero_state), 1);
    check({tag, "_dir"},   int'(direction), 0);
    check({tag, "_size"},  int'(step_size), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_left"},  int'(pulses_left), 0);
  endtask

  int t1_gaps[9]  = '{100, 80, 60, 40, 20, 20, 40, 60, 80};
  int t2_gaps[5]  = '{100, 80, 60, 40, 60};
  int t3_gaps[11] = '{100, 80, 60, 40, 20, 20, 20, 20, 40, 60, 80};
  int d;

  initial begin
    // Power-on reset.
    repeat (3) step();
    check_reset_outputs("rst0");
    check("rst0_ready", int'(cmd_ready), 1);
    rst = 1'b1;
    step();

    // 10 half steps clockwise.
    clear_log();
    send(10, 1'b1, 1'b0);
    wait_done(2000);
    repeat (5) step();
    check("t1_count", rise_cyc.size(), 10);
    if (rise_cyc.size() == 10) begin
      check("t1_first", rise_cyc[0], acc + 1);
      for (int i = 0; i < 9; i++)
        check($sformatf("t1_gap%0d", i), rise_cyc[i+1] - rise_cyc[i], t1_gaps[i]);
      check("t1_done_at", done_cyc[0], rise_cyc[9] + 4);
      for (int i = 0; i < 10; i++) begin
        check($sformatf("t1_dir%0d", i), rise_dir[i], 1);
        check($sformatf("t1_size%0d", i), rise_size[i], 0);
      end
    end
    for (int i = 0; i < widths.size(); i++)
      check($sformatf("t1_width%0d", i), widths[i], 4);
    check("t1_done_once", done_cyc.size(), 1);

    // 3 full steps counter-clockwise: 6 driver pulses.
    clear_log();
    send(3, 1'b0, 1'b1);
    wait_done(2000);
    step();
    check("t2_count", rise_cyc.size(), 6);
    if (rise_cyc.size() == 6) begin
      for (int i = 0; i < 5; i++)
        check($sformatf("t2_gap%0d", i), rise_cyc[i+1] - rise_cyc[i], t2_gaps[i]);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t2_left%0d", i), rise_left[i], 5 - i);
        check($sformatf("t2_busy%0d", i), rise_busy[i], 1);
        check($sformatf("t2_size%0d", i), rise_size[i], 1);
        check($sformatf("t2_dir%0d", i), rise_dir[i], 0);
      end
    end

    // Long move stopped after pulse 7; a second abort during decel is ignored.
    clear_log();
    send(100, 1'b1, 1'b0);
    wait_rises(7, 2000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_left_trim", int'(pulses_left), 5);
    wait_rises(9, 500);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_decel_abort_ignored", int'(pulses_left), 3);
    wait_done(2000);
    step();
    check("t3_count", rise_cyc.size(), 12);
    if (rise_cyc.size() == 12) begin
      for (int i = 0; i < 11; i++)
        check($sformatf("t3_gap%0d", i), rise_cyc[i+1] - rise_cyc[i], t3_gaps[i]);
      check("t3_done_at", done_cyc[0], rise_cyc[11] + 4);
    end
    check("t3_hold_zero", int'(zero_state), 0);
    check("t3_hold_ready", int'(cmd_ready), 1);
    check("t3_hold_busy", int'(busy), 0);

    // Hold expiry: one state of RELEASE setup, then the release pulse.
    d = (done_cyc.size() > 0) ? done_cyc[0] : cyc;
    clear_log();
    wait_rises(1, 1100);
    if (rise_cyc.size() > 0) begin
      check("t4_release_at", rise_cyc[0] - d, 1001);
      check("t4_release_zero", rise_zero[0], 1);
      check("t4_release_ready", rise_ready[0], 0);
      check("t4_release_busy", rise_busy[0], 0);
    end
    repeat (8) step();
    check("t4_release_count", rise_cyc.size(), 1);
    check("t4_release_width", (widths.size() > 0) ? widths[0] : 0, 4);
    check("t4_idle_ready", int'(cmd_ready), 1);
    check("t4_idle_zero", int'(zero_state), 1);

    // New command mid-hold: no release pulse, new move starts at once.
    clear_log();
    send(2, 1'b1, 1'b0);
    wait_done(1000);
    clear_log();
    repeat (498) step();
    check("t5_no_early_release", rise_cyc.size(), 0);
    send(1, 1'b0, 1'b1);
    wait_done(1000);
    step();
    check("t5_count", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      check("t5_first", rise_cyc[0], acc + 1);
      check("t5_gap", rise_cyc[1] - rise_cyc[0], 100);
      check("t5_zero0", rise_zero[0], 0);
      check("t5_zero1", rise_zero[1], 0);
      check("t5_dir", rise_dir[0], 0);
    end

    // Zero-length move.
    clear_log();
    send(0, 1'b1, 1'b1);
    repeat (20) step();
    check("t6_done_count", done_cyc.size(), 1);
    check("t6_done_at", (done_cyc.size() > 0) ? done_cyc[0] : 0, acc + 1);
    check("t6_no_pulse", rise_cyc.size(), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(cmd_ready), 1);
    check("t6_zero", int'(zero_state), 0);
    check("t6_dir", int'(direction), 1);
    check("t6_size", int'(step_size), 1);

    // Reset in the middle of a move.
    clear_log();
    send(10, 1'b1, 1'b0);
    wait_rises(3, 2000);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) step();
    rst = 1'b1;
    clear_log();
    repeat (200) step();
    check("rst_mid_no_pulse", rise_cyc.size(), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    check("rst_mid_zero", int'(zero_state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
